// File: rtl/calc_divrem_seq_pkg.sv
// Shared definitions for the sign-magnitude divide/remainder sequencer:
// opcode values, FSM state type and the result sign rule.
package calc_divrem_seq_pkg;

  localparam logic OP_QUO = 1'b0;
  localparam logic OP_REM = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Remainder takes the dividend sign; quotient takes the XOR of both signs.
  // Applied unconditionally, so zero magnitudes may carry a negative sign.
  function automatic logic res_sign(input logic op, input logic sign_a, input logic sign_b);
    return (op == OP_REM) ? sign_a : (sign_a ^ sign_b);
  endfunction

endpackage

// File: rtl/calc_divrem_seq_if.sv
// Request/result handshake bundle between the calculator front-end,
// the divide/remainder sequencer and the result display path.
interface calc_divrem_seq_if #(
  parameter int unsigned MAG_W = 2
);
  localparam int unsigned RES_W = 2 * MAG_W + 1;

  logic             in_valid;
  logic             in_ready;
  logic             op;
  logic [MAG_W:0]   a;
  logic [MAG_W:0]   b;
  logic             out_valid;
  logic             out_ready;
  logic [RES_W-1:0] res;
  logic             zero_div;

  // Front-end / consumer side
  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, res, zero_div
  );

  // Sequencer side
  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, res, zero_div
  );
endinterface

// File: rtl/calc_divrem_seq_divrem_step.sv
// One combinational restoring shift-subtract iteration: shift the next
// dividend bit into the partial remainder and subtract the divisor if it fits.
module divrem_step #(
  parameter int unsigned MAG_W = 2
) (
  input  logic [MAG_W:0]   rem_in,
  input  logic [MAG_W-1:0] quo_in,
  input  logic [MAG_W-1:0] divisor,
  output logic [MAG_W:0]   rem_out,
  output logic [MAG_W-1:0] quo_out
);

  logic [MAG_W+1:0] shifted;
  logic [MAG_W+1:0] trial;
  logic             fits;

  // Trial subtraction; the borrow bit decides whether the divisor fits.
  // The partial remainder always stays below the divisor, so the shifted
  // value never exceeds MAG_W+1 bits and the borrow bit is a valid sign.
  always_comb begin
    shifted = {rem_in, quo_in[MAG_W-1]};
    trial   = shifted - {2'b00, divisor};
    fits    = ~trial[MAG_W+1];
    rem_out = fits ? trial[MAG_W:0] : shifted[MAG_W:0];
    quo_out = (quo_in << 1) | MAG_W'(fits);
  end

endmodule

// File: rtl/calc_divrem_seq.sv
// Multi-cycle divide/remainder sequencer on sign-magnitude operands.
// Accepts one request, iterates one quotient bit per cycle, then holds the
// signed result until the consumer takes it.
module calc_divrem_seq
  import calc_divrem_seq_pkg::*;
#(
  parameter int unsigned MAG_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  calc_divrem_seq_if.slave   bus
);

  localparam int unsigned RES_W = 2 * MAG_W + 1;
  localparam int unsigned CNT_W = (MAG_W > 1) ? $clog2(MAG_W) : 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               op_q, op_d;
  logic               sign_a_q, sign_a_d;
  logic               sign_b_q, sign_b_d;
  logic [MAG_W-1:0]   div_q, div_d;
  logic [MAG_W:0]     rem_q, rem_d;
  logic [MAG_W-1:0]   quo_q, quo_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [RES_W-1:0]   res_q, res_d;
  logic               zero_div_q, zero_div_d;

  logic [MAG_W:0]     step_rem;
  logic [MAG_W-1:0]   step_quo;
  logic [RES_W-2:0]   mag;

  divrem_step #(.MAG_W(MAG_W)) u_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .divisor (div_q),
    .rem_out (step_rem),
    .quo_out (step_quo)
  );

  // Next-state, datapath and registered-output logic for IDLE/ITER/DONE.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    sign_a_d    = sign_a_q;
    sign_b_d    = sign_b_q;
    div_d       = div_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    res_d       = res_q;
    zero_div_d  = zero_div_q;
    mag         = '0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          op_d       = bus.op;
          sign_a_d   = bus.a[MAG_W];
          sign_b_d   = bus.b[MAG_W];
          div_d      = bus.b[MAG_W-1:0];
          in_ready_d = 1'b0;
          if (bus.b[MAG_W-1:0] == '0) begin
            state_d     = S_DONE;
            zero_div_d  = 1'b1;
            out_valid_d = 1'b1;
            res_d       = {res_sign(bus.op, bus.a[MAG_W], bus.b[MAG_W]), {(RES_W-1){1'b0}}};
          end else begin
            state_d    = S_ITER;
            zero_div_d = 1'b0;
            cnt_d      = CNT_W'(MAG_W - 1);
            rem_d      = '0;
            quo_d      = bus.a[MAG_W-1:0];
          end
        end
      end

      S_ITER: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          // Final iteration: result is formed straight from the step outputs
          // so out_valid rises on the same edge the FSM enters DONE.
          if (op_q == OP_REM) mag[MAG_W:0]   = step_rem;
          else                mag[MAG_W-1:0] = step_quo;
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          res_d       = {res_sign(op_q, sign_a_q, sign_b_q), mag};
        end
      end

      S_DONE: begin
        if (bus.out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end

      default: begin
        state_d     = S_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; async reset discards any in-flight request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_q        <= 1'b0;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      div_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      zero_div_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      sign_a_q    <= sign_a_d;
      sign_b_q    <= sign_b_d;
      div_q       <= div_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      zero_div_q  <= zero_div_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.res       = res_q;
  assign bus.zero_div  = zero_div_q;

endmodule

// File: tb/tb_calc_divrem_seq.sv
// Bench for calc_divrem_seq (MAG_W=2): directed vector table, backpressure
// and mid-operation reset sequences, exhaustive and random requests checked
// against an arithmetic reference model.
module tb_calc_divrem_seq;

  localparam int unsigned MAG_W = 2;
  localparam int unsigned RES_W = 2 * MAG_W + 1;

  logic clk;
  logic rst;

  calc_divrem_seq_if #(.MAG_W(MAG_W)) bus ();

  calc_divrem_seq #(.MAG_W(MAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic             op;
    logic [MAG_W:0]   a;
    logic [MAG_W:0]   b;
    logic [RES_W-1:0] res;
    logic             zd;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer division on magnitudes, then sign rules.
  function automatic logic [RES_W:0] ref_model(input logic op, input logic [MAG_W:0] a,
                                               input logic [MAG_W:0] b);
    int unsigned ma, mb, m;
    logic sgn, zd;
    ma = int'(a) % (1 << MAG_W);
    mb = int'(b) % (1 << MAG_W);
    zd = (mb == 0);
    if (zd)      m = 0;
    else if (op) m = ma % mb;
    else         m = ma / mb;
    sgn = op ? a[MAG_W] : (a[MAG_W] ^ b[MAG_W]);
    return {zd, sgn, (RES_W-1)'(m)};
  endfunction

  // One full request: accept, latency, stalled hold, then handoff.
  task automatic run_req(input logic op_i, input logic [MAG_W:0] a_i, input logic [MAG_W:0] b_i,
                         input int stall);
    logic [RES_W:0] exp;
    int lat, exp_lat, w;
    exp = ref_model(op_i, a_i, b_i);
    exp_lat = exp[RES_W] ? 1 : MAG_W + 1;
    w = 0;
    while (bus.in_ready !== 1'b1 && w < 20) begin
      @(posedge clk); #1; w++;
    end
    check("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.op = op_i;
    bus.a  = a_i;
    bus.b  = b_i;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.op = 1'($urandom);
    bus.a  = (MAG_W+1)'($urandom);
    bus.b  = (MAG_W+1)'($urandom);
    check("in_ready_busy", 32'(bus.in_ready), 32'd0);
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      bus.out_ready = 1'($urandom);
      @(posedge clk); #1; lat++;
    end
    bus.out_ready = 1'b0;
    check("latency", 32'(lat), 32'(exp_lat));
    check("res", 32'(bus.res), 32'(exp[RES_W-1:0]));
    check("zero_div", 32'(bus.zero_div), 32'(exp[RES_W]));
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_res", 32'(bus.res), 32'(exp[RES_W-1:0]));
      check("hold_zd", 32'(bus.zero_div), 32'(exp[RES_W]));
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("post_valid", 32'(bus.out_valid), 32'd0);
    check("post_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    vecs[0] = '{1'b1, 3'b011, 3'b010, 5'b00001, 1'b0};
    vecs[1] = '{1'b0, 3'b011, 3'b010, 5'b00001, 1'b0};
    vecs[2] = '{1'b1, 3'b111, 3'b010, 5'b10001, 1'b0};
    vecs[3] = '{1'b0, 3'b111, 3'b010, 5'b10001, 1'b0};
    vecs[4] = '{1'b0, 3'b110, 3'b101, 5'b00010, 1'b0};
    vecs[5] = '{1'b1, 3'b110, 3'b100, 5'b10000, 1'b1};
    vecs[6] = '{1'b0, 3'b010, 3'b000, 5'b00000, 1'b1};

    bus.in_valid  = 1'b0;
    bus.op        = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    #12;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_res", 32'(bus.res), 32'd0);
    check("rst_zero_div", 32'(bus.zero_div), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed table, with the table's own expected values cross-checked
    for (int i = 0; i < 7; i++) begin
      logic [RES_W:0] m;
      m = ref_model(vecs[i].op, vecs[i].a, vecs[i].b);
      check("table_model", 32'(m), 32'({vecs[i].zd, vecs[i].res}));
      run_req(vecs[i].op, vecs[i].a, vecs[i].b, 0);
    end

    // Backpressure: five stalled cycles in DONE
    run_req(1'b0, 3'b011, 3'b001, 5);

    // Async reset in the middle of an iteration
    bus.in_valid = 1'b1;
    bus.op = 1'b0;
    bus.a  = 3'b011;
    bus.b  = 3'b001;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #3 rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_res", 32'(bus.res), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    #7 rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      check("no_stale_valid", 32'(bus.out_valid), 32'd0);
      check("no_stale_in_ready", 32'(bus.in_ready), 32'd1);
    end
    bus.out_ready = 1'b0;

    // Exhaustive operand space with random stalls
    for (int op = 0; op < 2; op++)
      for (int a = 0; a < 8; a++)
        for (int b = 0; b < 8; b++)
          run_req(1'(op), 3'(a), 3'(b), int'($urandom_range(0, 3)));

    // Random requests
    for (int r = 0; r < 40; r++)
      run_req(1'($urandom), 3'($urandom), 3'($urandom), int'($urandom_range(0, 2)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound so a stuck handshake still ends the run.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

endmodule
